// File: rtl/sysbus_pkg.sv
// rtl/sysbus_pkg.sv - Sysbus tag layout, device codes, line geometry and responder state type
package sysbus_pkg;

    localparam int TAG_RW_BIT  = 12;
    localparam int TAG_DEV_LSB = 8;
    localparam int TAG_DEV_W   = 4;

    localparam logic SYSBUS_READ  = 1'b1;
    localparam logic SYSBUS_WRITE = 1'b0;

    localparam logic [TAG_DEV_W-1:0] SYSBUS_MEMORY = 4'h1;

    localparam int LINE_BEATS = 8;
    localparam int BEAT_BYTES = 8;
    localparam int LINE_BYTES = LINE_BEATS * BEAT_BYTES;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_DATA = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RD_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/sysbus_mem_responder_if.sv
// rtl/sysbus_mem_responder_if.sv - Sysbus request/response signal bundle with initiator/responder views
interface sysbus_if #(
    parameter int DW = 64,
    parameter int TW = 13
);
    logic          bus_reqcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          bus_respack;

    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );
endinterface

// File: rtl/sysbus_mem_array.sv
// rtl/sysbus_mem_array.sv - Single-port word array with sync write and registered read data
module sysbus_mem_array #(
    parameter int DW = 64,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic          i_re,
    input  logic          i_rzero,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= i_rzero ? '0 : r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/sysbus_mem_responder.sv
// rtl/sysbus_mem_responder.sv - Sysbus memory responder: request FSM, burst sequencing, tag echo
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int READ_LATENCY   = 4,
    parameter int BEATS          = LINE_BEATS
) (
    input  logic    clk,
    input  logic    reset,
    sysbus_if.slave bus
);
    localparam int AW       = $clog2(MEM_WORDS);
    localparam int BW       = $clog2(BEATS);
    localparam int LW       = AW - BW;
    localparam int LINE_LSB = 3 + BW;
    localparam int LAT_W    = $clog2(READ_LATENCY) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    state_t                   r_state, w_state_nxt;
    logic                     r_ack, w_ack_nxt;
    logic                     r_respcyc, w_respcyc_nxt;
    logic [BW-1:0]            r_beat, w_beat_nxt;
    logic [LAT_W-1:0]         r_lat, w_lat_nxt;
    logic [BUS_TAG_WIDTH-1:0] r_tag, w_tag_nxt;
    logic [LW-1:0]            r_line, w_line_nxt;
    logic                     r_oor, w_oor_nxt;

    logic                      w_we;
    logic                      w_re;
    logic [BW-1:0]             w_mem_beat;
    logic                      w_dev_hit;
    logic                      w_req_oor;
    logic [BUS_DATA_WIDTH-1:0] w_rdata;

    assign w_dev_hit = bus.bus_reqtag[TAG_DEV_LSB +: TAG_DEV_W] == SYSBUS_MEMORY;
    assign w_req_oor = |bus.bus_req[BUS_DATA_WIDTH-1:3+AW];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_ack     <= 1'b0;
            r_respcyc <= 1'b0;
            r_beat    <= '0;
            r_lat     <= '0;
            r_tag     <= '0;
            r_line    <= '0;
            r_oor     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ack     <= w_ack_nxt;
            r_respcyc <= w_respcyc_nxt;
            r_beat    <= w_beat_nxt;
            r_lat     <= w_lat_nxt;
            r_tag     <= w_tag_nxt;
            r_line    <= w_line_nxt;
            r_oor     <= w_oor_nxt;
        end
    end

    // A beat is only consumed when no ack went out last cycle, so a late-dropping
    // initiator is never counted twice.
    always_comb begin
        w_state_nxt   = r_state;
        w_ack_nxt     = 1'b0;
        w_respcyc_nxt = r_respcyc;
        w_beat_nxt    = r_beat;
        w_lat_nxt     = r_lat;
        w_tag_nxt     = r_tag;
        w_line_nxt    = r_line;
        w_oor_nxt     = r_oor;
        w_we          = 1'b0;
        w_re          = 1'b0;
        w_mem_beat    = r_beat;
        case (r_state)
            ST_IDLE: begin
                if (bus.bus_reqcyc && !r_ack && w_dev_hit) begin
                    w_ack_nxt  = 1'b1;
                    w_tag_nxt  = bus.bus_reqtag;
                    w_line_nxt = bus.bus_req[LINE_LSB +: LW];
                    w_oor_nxt  = w_req_oor;
                    w_beat_nxt = '0;
                    if (bus.bus_reqtag[TAG_RW_BIT] == SYSBUS_READ) begin
                        w_state_nxt = ST_RD_WAIT;
                        w_lat_nxt   = LAT_W'(READ_LATENCY - 1);
                    end else begin
                        w_state_nxt = ST_WR_DATA;
                    end
                end
            end
            ST_WR_DATA: begin
                if (bus.bus_reqcyc && !r_ack) begin
                    w_ack_nxt  = 1'b1;
                    w_we       = !r_oor;
                    w_beat_nxt = r_beat + 1'b1;
                    if (r_beat == LAST_BEAT) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (r_lat == '0) begin
                    w_state_nxt = ST_RD_RESP;
                    w_beat_nxt  = '0;
                end else begin
                    w_lat_nxt = r_lat - 1'b1;
                end
            end
            ST_RD_RESP: begin
                // Read port is addressed with the beat about to be shown so bursts stay gapless.
                if (!r_respcyc) begin
                    w_re          = 1'b1;
                    w_respcyc_nxt = 1'b1;
                end else if (bus.bus_respack) begin
                    if (r_beat == LAST_BEAT) begin
                        w_respcyc_nxt = 1'b0;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_beat_nxt = r_beat + 1'b1;
                        w_mem_beat = r_beat + 1'b1;
                        w_re       = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    sysbus_mem_array #(
        .DW (BUS_DATA_WIDTH),
        .AW (AW)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_rzero (r_oor),
        .i_addr  ({r_line, w_mem_beat}),
        .i_wdata (bus.bus_req),
        .o_rdata (w_rdata)
    );

    assign bus.bus_reqack  = r_ack;
    assign bus.bus_respcyc = r_respcyc;
    assign bus.bus_resp    = w_rdata;
    assign bus.bus_resptag = r_tag;
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb/tb_sysbus_mem_responder.sv - Self-checking bench for sysbus_mem_responder against a line-level memory model
module tb_sysbus_mem_responder;
    import sysbus_pkg::*;

    localparam int MEM_WORDS = 4096;
    localparam int LAT       = 4;
    localparam int BEATS     = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sysbus_if #(.DW(64), .TW(13)) bus();

    sysbus_mem_responder #(
        .BUS_DATA_WIDTH (64),
        .BUS_TAG_WIDTH  (13),
        .MEM_WORDS      (MEM_WORDS),
        .READ_LATENCY   (LAT),
        .BEATS          (BEATS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int   ack_count    = 0;
    int   resp_cycles  = 0;
    int   ack_adjacent = 0;
    logic prev_ack     = 1'b0;

    logic [63:0] model_mem [MEM_WORDS];

    always @(negedge clk) begin
        if (reset) begin
            if (bus.bus_reqack) ack_count++;
            if (bus.bus_reqack && prev_ack) ack_adjacent++;
            if (bus.bus_respcyc) resp_cycles++;
            prev_ack = bus.bus_reqack;
        end else begin
            prev_ack = 1'b0;
        end
    end

    function automatic bit in_range(input logic [63:0] a);
        return a < 64'(8 * MEM_WORDS);
    endfunction

    function automatic int line_word(input logic [63:0] a);
        int w;
        w = int'(a >> 3);
        return w - (w % BEATS);
    endfunction

    function automatic logic [63:0] model_read(input logic [63:0] a, input int b);
        if (!in_range(a)) return 64'h0;
        return model_mem[line_word(a) + b];
    endfunction

    task automatic model_write(input logic [63:0] a, input logic [63:0] d [BEATS]);
        if (in_range(a)) begin
            for (int b = 0; b < BEATS; b++) model_mem[line_word(a) + b] = d[b];
        end
    endtask

    task automatic drive_beat(input logic [63:0] v, input logic [12:0] tag, output bit acked);
        bus.bus_reqcyc = 1'b1;
        bus.bus_req    = v;
        bus.bus_reqtag = tag;
        acked = 1'b0;
        for (int c = 0; c < 40 && !acked; c++) begin
            @(negedge clk);
            if (bus.bus_reqack) acked = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [63:0] a, input logic [12:0] tag,
                             input logic [63:0] d [BEATS], output bit ok);
        bit acked;
        drive_beat(a, tag, acked);
        ok = acked;
        for (int i = 0; i < BEATS; i++) begin
            drive_beat(d[i], tag, acked);
            ok = ok && acked;
        end
        bus.bus_reqcyc = 1'b0;
    endtask

    task automatic bus_read(input logic [63:0] a, input logic [12:0] tag,
                            input int stall_beat, input int stall_len,
                            output logic [63:0] beats [BEATS], output logic [12:0] tags [BEATS],
                            output int lat, output int hold_err, output bit dropped, output bit timeout);
        bit          acked;
        bit          fresh;
        int          bi;
        int          stall_left;
        logic [63:0] hv;
        logic [12:0] ht;
        hold_err = 0; dropped = 1'b0; timeout = 1'b0; lat = 0;
        hv = '0; ht = '0;
        for (int i = 0; i < BEATS; i++) begin beats[i] = '0; tags[i] = '0; end
        bus.bus_respack = 1'b1;
        drive_beat(a, tag, acked);
        bus.bus_reqcyc = 1'b0;
        if (!acked) begin timeout = 1'b1; return; end
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            lat++;
            if (bus.bus_respcyc) break;
        end
        if (!bus.bus_respcyc) begin timeout = 1'b1; return; end
        bi = 0; fresh = 1'b1;
        stall_left = (stall_beat == 0) ? stall_len : 0;
        for (int c = 0; c < 200 && bi < BEATS; c++) begin
            if (c > 0) @(negedge clk);
            if (!bus.bus_respcyc) begin
                hold_err++;
                bus.bus_respack = 1'b1;
            end else begin
                if (fresh) begin
                    hv = bus.bus_resp; ht = bus.bus_resptag; fresh = 1'b0;
                end else if (bus.bus_resp !== hv || bus.bus_resptag !== ht) begin
                    hold_err++;
                end
                if (stall_left > 0) begin
                    bus.bus_respack = 1'b0;
                    stall_left--;
                end else begin
                    bus.bus_respack = 1'b1;
                    beats[bi] = hv; tags[bi] = ht;
                    bi++; fresh = 1'b1;
                    if (bi == stall_beat) stall_left = stall_len;
                end
            end
        end
        if (bi < BEATS) begin timeout = 1'b1; return; end
        @(negedge clk);
        dropped = !bus.bus_respcyc;
        bus.bus_respack = 1'b1;
    endtask

    task automatic test_reset;
        bus.bus_reqcyc = 1'b0; bus.bus_req = '0; bus.bus_reqtag = '0; bus.bus_respack = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_tests++; if (bus.bus_reqack !== 1'b0) begin n_fail++; $display("FAIL reset_reqack: got %b want 0", bus.bus_reqack); end
        n_tests++; if (bus.bus_respcyc !== 1'b0) begin n_fail++; $display("FAIL reset_respcyc: got %b want 0", bus.bus_respcyc); end
        n_tests++; if (bus.bus_resp !== 64'h0) begin n_fail++; $display("FAIL reset_resp: got %h want 0", bus.bus_resp); end
        n_tests++; if (bus.bus_resptag !== 13'h0) begin n_fail++; $display("FAIL reset_resptag: got %h want 0", bus.bus_resptag); end
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (bus.bus_respcyc !== 1'b0 || bus.bus_reqack !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: respcyc %b reqack %b want 0 0", bus.bus_respcyc, bus.bus_reqack);
        end
    endtask

    task automatic init_memory;
        logic [63:0] d [BEATS];
        bit          ok;
        int          bad;
        bad = 0;
        for (int l = 0; l < MEM_WORDS / BEATS; l++) begin
            for (int b = 0; b < BEATS; b++) d[b] = 64'(l * BEATS + b);
            bus_write(64'(l * BEATS * 8), {SYSBUS_WRITE, SYSBUS_MEMORY, 8'(l)}, d, ok);
            model_write(64'(l * BEATS * 8), d);
            if (!ok) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL init_write_acks: %0d lines unacked, want 0", bad); end
    endtask

    task automatic test_read_latency;
        logic [63:0] beats [BEATS];
        logic [12:0] tags [BEATS];
        logic [12:0] tag;
        int lat, hold_err, acks0;
        bit dropped, timeout;
        tag = {SYSBUS_READ, SYSBUS_MEMORY, 8'h2A};
        acks0 = ack_count;
        bus_read(64'h45, tag, -1, 0, beats, tags, lat, hold_err, dropped, timeout);
        n_tests++; if (timeout) begin n_fail++; $display("FAIL read_lat_timeout: burst incomplete"); end
        n_tests++; if (lat != LAT + 1) begin n_fail++; $display("FAIL read_latency: got %0d want %0d", lat, LAT + 1); end
        n_tests++; if (ack_count - acks0 != 1) begin n_fail++; $display("FAIL read_acks: got %0d want 1", ack_count - acks0); end
        for (int b = 0; b < BEATS; b++) begin
            n_tests++; if (beats[b] !== 64'(8 + b)) begin n_fail++; $display("FAIL read_beat%0d: got %h want %h", b, beats[b], 64'(8 + b)); end
            n_tests++; if (tags[b] !== 13'h112A) begin n_fail++; $display("FAIL read_tag%0d: got %h want 112a", b, tags[b]); end
        end
        n_tests++; if (hold_err != 0) begin n_fail++; $display("FAIL read_gapless: %0d bad cycles want 0", hold_err); end
        n_tests++; if (!dropped) begin n_fail++; $display("FAIL read_drop: respcyc still 1 want 0"); end
    endtask

    task automatic test_write_read;
        logic [63:0] d [BEATS];
        logic [63:0] beats [BEATS];
        logic [12:0] tags [BEATS];
        int lat, hold_err, acks0, resp0;
        bit ok, dropped, timeout;
        for (int b = 0; b < BEATS; b++) d[b] = {$urandom, $urandom};
        acks0 = ack_count; resp0 = resp_cycles;
        bus_write(64'h100, {SYSBUS_WRITE, SYSBUS_MEMORY, 8'h05}, d, ok);
        model_write(64'h100, d);
        repeat (3) @(posedge clk);
        n_tests++; if (ack_count - acks0 != BEATS + 1) begin n_fail++; $display("FAIL write_acks: got %0d want %0d", ack_count - acks0, BEATS + 1); end
        n_tests++; if (resp_cycles != resp0) begin n_fail++; $display("FAIL write_no_resp: got %0d resp cycles want 0", resp_cycles - resp0); end
        bus_read(64'h100, {SYSBUS_READ, SYSBUS_MEMORY, 8'h06}, -1, 0, beats, tags, lat, hold_err, dropped, timeout);
        n_tests++; if (timeout) begin n_fail++; $display("FAIL wr_rd_timeout: burst incomplete"); end
        for (int b = 0; b < BEATS; b++) begin
            n_tests++; if (beats[b] !== d[b]) begin n_fail++; $display("FAIL wr_rd_beat%0d: got %h want %h", b, beats[b], d[b]); end
        end
    endtask

    task automatic test_stall;
        logic [63:0] beats [BEATS];
        logic [12:0] tags [BEATS];
        logic [63:0] a;
        int lat, hold_err, resp0;
        bit dropped, timeout;
        a = 64'($urandom_range(0, 8 * MEM_WORDS - 1));
        resp0 = resp_cycles;
        bus_read(a, {SYSBUS_READ, SYSBUS_MEMORY, 8'h77}, 2, 3, beats, tags, lat, hold_err, dropped, timeout);
        n_tests++; if (timeout) begin n_fail++; $display("FAIL stall_timeout: burst incomplete"); end
        n_tests++; if (hold_err != 0) begin n_fail++; $display("FAIL stall_hold: %0d unstable cycles want 0", hold_err); end
        n_tests++; if (resp_cycles - resp0 != BEATS + 3) begin n_fail++; $display("FAIL stall_resp_cycles: got %0d want %0d", resp_cycles - resp0, BEATS + 3); end
        n_tests++; if (!dropped) begin n_fail++; $display("FAIL stall_drop: respcyc still 1 want 0"); end
        for (int b = 0; b < BEATS; b++) begin
            n_tests++; if (beats[b] !== model_read(a, b)) begin n_fail++; $display("FAIL stall_beat%0d: got %h want %h", b, beats[b], model_read(a, b)); end
        end
    endtask

    task automatic test_foreign_device;
        int acks0, resp0;
        acks0 = ack_count; resp0 = resp_cycles;
        bus.bus_reqcyc = 1'b1; bus.bus_req = 64'h200; bus.bus_reqtag = {SYSBUS_READ, 4'h2, 8'h11};
        repeat (20) @(posedge clk);
        #1 bus.bus_reqcyc = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #1;
        n_tests++; if (ack_count != acks0) begin n_fail++; $display("FAIL foreign_ack: got %0d acks want 0", ack_count - acks0); end
        n_tests++; if (resp_cycles != resp0) begin n_fail++; $display("FAIL foreign_resp: got %0d resp cycles want 0", resp_cycles - resp0); end
    endtask

    task automatic test_reset_mid_burst;
        logic [63:0] beats [BEATS];
        logic [12:0] tags [BEATS];
        logic [63:0] a;
        int lat, hold_err, seen;
        bit acked, dropped, timeout;
        a = 64'h1C0;
        bus.bus_respack = 1'b1;
        drive_beat(a, {SYSBUS_READ, SYSBUS_MEMORY, 8'h33}, acked);
        bus.bus_reqcyc = 1'b0;
        seen = 0;
        for (int c = 0; c < 100 && seen < 4; c++) begin
            @(negedge clk);
            if (bus.bus_respcyc) seen++;
        end
        n_tests++; if (seen != 4) begin n_fail++; $display("FAIL midrst_reach_beat3: got %0d beats want 4", seen); end
        #2 reset = 1'b0;
        #1;
        n_tests++; if (bus.bus_respcyc !== 1'b0) begin n_fail++; $display("FAIL midrst_respcyc: got %b want 0", bus.bus_respcyc); end
        n_tests++; if (bus.bus_resp !== 64'h0) begin n_fail++; $display("FAIL midrst_resp: got %h want 0", bus.bus_resp); end
        n_tests++; if (bus.bus_resptag !== 13'h0) begin n_fail++; $display("FAIL midrst_resptag: got %h want 0", bus.bus_resptag); end
        n_tests++; if (bus.bus_reqack !== 1'b0) begin n_fail++; $display("FAIL midrst_reqack: got %b want 0", bus.bus_reqack); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        bus_read(64'h2C8, {SYSBUS_READ, SYSBUS_MEMORY, 8'h34}, -1, 0, beats, tags, lat, hold_err, dropped, timeout);
        n_tests++; if (timeout || !dropped) begin n_fail++; $display("FAIL midrst_after_burst: timeout %b dropped %b want 0 1", timeout, dropped); end
        for (int b = 0; b < BEATS; b++) begin
            n_tests++; if (beats[b] !== model_read(64'h2C8, b)) begin n_fail++; $display("FAIL midrst_beat%0d: got %h want %h", b, beats[b], model_read(64'h2C8, b)); end
        end
    endtask

    task automatic test_out_of_range;
        logic [63:0] d [BEATS];
        logic [63:0] beats [BEATS];
        logic [12:0] tags [BEATS];
        logic [63:0] oor;
        int lat, hold_err, acks0;
        bit ok, dropped, timeout;
        oor = 64'(8 * MEM_WORDS);
        bus_read(oor, {SYSBUS_READ, SYSBUS_MEMORY, 8'h40}, -1, 0, beats, tags, lat, hold_err, dropped, timeout);
        n_tests++; if (timeout || !dropped) begin n_fail++; $display("FAIL oor_read_burst: timeout %b dropped %b want 0 1", timeout, dropped); end
        for (int b = 0; b < BEATS; b++) begin
            n_tests++; if (beats[b] !== 64'h0) begin n_fail++; $display("FAIL oor_read_beat%0d: got %h want 0", b, beats[b]); end
        end
        for (int b = 0; b < BEATS; b++) d[b] = {$urandom, $urandom} | 64'h1;
        acks0 = ack_count;
        bus_write(oor, {SYSBUS_WRITE, SYSBUS_MEMORY, 8'h41}, d, ok);
        model_write(oor, d);
        @(posedge clk); #1;
        n_tests++; if (ack_count - acks0 != BEATS + 1) begin n_fail++; $display("FAIL oor_write_acks: got %0d want %0d", ack_count - acks0, BEATS + 1); end
        bus_read(64'h0, {SYSBUS_READ, SYSBUS_MEMORY, 8'h42}, -1, 0, beats, tags, lat, hold_err, dropped, timeout);
        for (int b = 0; b < BEATS; b++) begin
            n_tests++; if (beats[b] !== model_read(64'h0, b)) begin n_fail++; $display("FAIL oor_alias_beat%0d: got %h want %h", b, beats[b], model_read(64'h0, b)); end
        end
    endtask

    task automatic test_random;
        logic [63:0] d [BEATS];
        logic [63:0] beats [BEATS];
        logic [12:0] tags [BEATS];
        logic [63:0] a;
        logic [12:0] tag;
        int lat, hold_err, acks0, sb, sl;
        bit ok, dropped, timeout;
        for (int op = 0; op < 40; op++) begin
            case ($urandom_range(0, 7))
                0:       a = 64'(8 * MEM_WORDS) + 64'($urandom_range(0, 100000));
                1:       a = {32'h1, $urandom};
                default: a = 64'($urandom_range(0, 8 * MEM_WORDS - 1));
            endcase
            if ($urandom_range(0, 2) == 0) begin
                for (int b = 0; b < BEATS; b++) d[b] = {$urandom, $urandom};
                tag = {SYSBUS_WRITE, SYSBUS_MEMORY, 8'($urandom)};
                acks0 = ack_count;
                bus_write(a, tag, d, ok);
                model_write(a, d);
                n_tests++; if (!ok || ack_count - acks0 != BEATS + 1) begin
                    n_fail++; $display("FAIL rand_write_acks op%0d: got %0d want %0d", op, ack_count - acks0, BEATS + 1);
                end
            end else begin
                tag = {SYSBUS_READ, SYSBUS_MEMORY, 8'($urandom)};
                sb = $urandom_range(0, BEATS - 1);
                sl = $urandom_range(0, 3);
                bus_read(a, tag, sb, sl, beats, tags, lat, hold_err, dropped, timeout);
                n_tests++; if (timeout || !dropped || hold_err != 0) begin
                    n_fail++; $display("FAIL rand_read_proto op%0d: timeout %b dropped %b hold_err %0d want 0 1 0", op, timeout, dropped, hold_err);
                end
                n_tests++; if (sb != 0 && lat != LAT + 1) begin
                    n_fail++; $display("FAIL rand_read_latency op%0d: got %0d want %0d", op, lat, LAT + 1);
                end
                for (int b = 0; b < BEATS; b++) begin
                    n_tests++; if (beats[b] !== model_read(a, b) || tags[b] !== tag) begin
                        n_fail++; $display("FAIL rand_read_beat op%0d b%0d: got %h/%h want %h/%h", op, b, beats[b], tags[b], model_read(a, b), tag);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset;
        init_memory;
        test_read_latency;
        test_write_read;
        test_stall;
        test_foreign_device;
        test_reset_mid_burst;
        test_out_of_range;
        test_random;
        n_tests++; if (ack_adjacent != 0) begin n_fail++; $display("FAIL ack_spacing: %0d back-to-back acks want 0", ack_adjacent); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
